// File: rtl/mult_engine.sv
// Sequential shift-and-add unsigned multiplier: W CALC cycles per product,
// launched by a level request that must drop before the calculation begins.
module mult_engine #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           eng_start,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  output logic           eng_done,
  output logic           busy,
  output logic [2*W-1:0] product
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, HOLD, CALC, DONE} state_t;

  state_t           state;
  logic [W-1:0]     mcand;
  logic [W-1:0]     mplier;
  logic [2*W-1:0]   acc;
  logic [CW-1:0]    cnt;
  logic [W:0]       upper_sum;
  logic [2*W:0]     acc_wide;
  logic [2*W-1:0]   acc_step;

  // Add into the upper half keeping the carry, then shift the whole thing right.
  always_comb begin
    upper_sum = {1'b0, acc[2*W-1:W]} + {1'b0, (mplier[0] ? mcand : '0)};
    acc_wide  = {upper_sum, acc[W-1:0]};
    acc_step  = acc_wide[2*W:1];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      product  <= '0;
      eng_done <= 1'b0;
    end else begin
      eng_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (eng_start) begin
            mcand  <= a_in;
            mplier <= b_in;
            acc    <= '0;
            cnt    <= '0;
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (!eng_start) state <= CALC;
        end
        CALC: begin
          acc    <= acc_step;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            product  <= acc_step;
            eng_done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_engine.sv
// Directed-vector bench for mult_engine (W=8): latency, results, hold-off,
// operand/request isolation, mid-calculation reset and back-to-back requests.
module tb_mult_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        eng_start;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        eng_done;
  logic        busy;
  logic [15:0] product;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_prod = 16'h0000;

  mult_engine #(.W(8)) dut (
    .clk(clk), .rst(rst), .eng_start(eng_start), .a_in(a_in), .b_in(b_in),
    .eng_done(eng_done), .busy(busy), .product(product)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; eng_start = 1'b0; a_in = '0; b_in = '0;
    tick(); tick();
    n_tests++;
    if (product !== 16'h0000) begin n_fail++; $display("FAIL reset_product got=%h exp=0000", product); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++;
    if (eng_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", eng_done); end
    rst = 1'b0;
    tick();
  endtask

  // Entered and left at #1 after an edge with the FSM in IDLE (or DONE when tail=0).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                        input bit perturb, input bit tail, input logic [15:0] exp_p,
                        input string name);
    int  lat = 0;
    int  busy_cnt = 0;
    bit  stable = 1'b1;
    bit  seen = 1'b0;
    a_in = a; b_in = b; eng_start = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (product !== exp_prod) stable = 1'b0;
    end
    eng_start = 1'b0;
    a_in = 8'hA5; b_in = 8'h5A;
    while (!seen && lat < 40) begin
      tick();
      lat++;
      if (busy) busy_cnt++;
      if (eng_done) seen = 1'b1;
      else if (product !== exp_prod) stable = 1'b0;
      if (perturb && lat == 3) begin a_in = 8'd1; b_in = 8'd1; eng_start = 1'b1; end
      if (perturb && lat == 5) eng_start = 1'b0;
    end
    n_tests++;
    if (!seen || lat !== 9) begin n_fail++; $display("FAIL %s_latency got=%0d exp=9 seen=%b", name, lat, seen); end
    n_tests++;
    if (product !== exp_p) begin n_fail++; $display("FAIL %s_product got=%h exp=%h", name, product, exp_p); end
    n_tests++;
    if (!stable) begin n_fail++; $display("FAIL %s_product_hold changed before DONE prev=%h", name, exp_prod); end
    exp_prod = exp_p;
    if (tail) begin
      int extra_done = 0;
      int extra_busy = 0;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (eng_done) extra_done++;
        if (busy) extra_busy++;
      end
      n_tests++;
      if (busy_cnt + (hold - 1) * 0 !== 9 + hold) begin n_fail++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, busy_cnt, 9 + hold); end
      n_tests++;
      if (extra_done !== 0) begin n_fail++; $display("FAIL %s_single_done extra=%0d exp=0", name, extra_done); end
      n_tests++;
      if (extra_busy !== 0) begin n_fail++; $display("FAIL %s_idle_after busy_cycles=%0d exp=0", name, extra_busy); end
      n_tests++;
      if (product !== exp_p) begin n_fail++; $display("FAIL %s_product_retained got=%h exp=%h", name, product, exp_p); end
    end
  endtask

  task automatic test_basic();
    run_op(8'd13, 8'd11, 1, 1'b0, 1'b1, 16'h008F, "mul13x11");
  endtask

  task automatic test_boundaries();
    run_op(8'd255, 8'd255, 1, 1'b0, 1'b1, 16'hFE01, "mul255x255");
    run_op(8'd0, 8'd200, 1, 1'b0, 1'b1, 16'h0000, "mul0x200");
    run_op(8'd200, 8'd0, 1, 1'b0, 1'b1, 16'h0000, "mul200x0");
  endtask

  task automatic test_hold_start();
    run_op(8'd6, 8'd7, 4, 1'b0, 1'b1, 16'd42, "hold6x7");
  endtask

  task automatic test_ignore_inputs();
    run_op(8'd20, 8'd30, 1, 1'b1, 1'b1, 16'd600, "isolate20x30");
  endtask

  task automatic test_mid_reset();
    int dones = 0;
    int busies = 0;
    a_in = 8'd9; b_in = 8'd9; eng_start = 1'b1;
    tick();
    eng_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if (product !== 16'h0000) begin n_fail++; $display("FAIL midrst_product got=%h exp=0000", product); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    #1 rst = 1'b0;
    exp_prod = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (eng_done) dones++;
      if (busy) busies++;
    end
    n_tests++;
    if (dones !== 0 || busies !== 0) begin n_fail++; $display("FAIL midrst_abort dones=%0d busy=%0d exp=0/0", dones, busies); end
    run_op(8'd3, 8'd5, 1, 1'b0, 1'b1, 16'd15, "after_rst3x5");
  endtask

  task automatic test_back_to_back();
    run_op(8'd100, 8'd3, 1, 1'b0, 1'b0, 16'd300, "b2b_first");
    tick();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap busy=%b exp=0", busy); end
    run_op(8'd77, 8'd2, 1, 1'b0, 1'b1, 16'd154, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_hold_start();
    test_ignore_inputs();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
